// File: rtl/click_pkg.sv
// Shared types and constants for the click-pipeline receiver.
package click_pkg;
  localparam int CLICK_DW_DEF = 2;
  localparam int RX_CNT_W     = 16;

  typedef enum logic {
    RX_IDLE,
    RX_FULL_WAIT
  } rx_state_t;
endpackage

// File: rtl/click_rx_sync_if.sv
// Click-side 2-phase handshake plus clocked valid/ready stream of the receiver.
interface click_rx_sync_if
  import click_pkg::*;
#(
   parameter int DW = CLICK_DW_DEF
);
   logic          in_req;
   logic [DW-1:0] in_data;
   logic          in_ack;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;

   modport master (output in_req, in_data, out_ready,
                   input  in_ack, out_valid, out_data);
   modport slave  (input  in_req, in_data, out_ready,
                   output in_ack, out_valid, out_data);
endinterface

// File: rtl/click_sync.sv
// Multi-flop 1-bit synchronizer, cleared by synchronous reset.
module click_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[STAGES-2:0], d};
   end

   assign q = sync_q[STAGES-1];
endmodule

// File: rtl/click_rx_sync.sv
// Receiver bridging a 2-phase click chain into a clocked valid/ready stream via a small FIFO.
// Optional token counter port rx_count enabled with `define CLICK_RX_CNT_EN.
module click_rx_sync
  import click_pkg::*;
#(
   parameter int DW          = CLICK_DW_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int DEPTH       = 4
) (
   input  logic            clk,
   input  logic            reset,
   click_rx_sync_if.slave  rx
`ifdef CLICK_RX_CNT_EN
   ,
   output logic [RX_CNT_W-1:0] rx_count
`endif
);
   localparam int AW = $clog2(DEPTH);

   logic          req_s;
   logic          ack_r;
   logic          pending;
   logic          space;
   logic          capture;
   logic          pop;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   rx_state_t     state_q;
   rx_state_t     state_d;

   click_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx.in_req),
      .q     (req_s)
   );

   // Level compare: a token stays pending until acked, so none can be missed.
   assign pending = req_s ^ ack_r;
   assign pop     = rx.out_valid & rx.out_ready;
   assign space   = (count < (AW+1)'(DEPTH)) | pop;
   assign capture = pending & space;

   always_comb begin
      state_d = state_q;
      case (state_q)
         RX_IDLE:      if (pending && !space) state_d = RX_FULL_WAIT;
         RX_FULL_WAIT: if (space)             state_d = RX_IDLE;
         default:                             state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RX_IDLE;
         ack_r   <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            mem[wr_ptr] <= rx.in_data;
            wr_ptr      <= wr_ptr + 1'b1;
            ack_r       <= ~ack_r;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({capture, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rx.in_ack    = ack_r;
   assign rx.out_valid = (count != '0);
   assign rx.out_data  = mem[rd_ptr];

`ifdef CLICK_RX_CNT_EN
   logic [RX_CNT_W-1:0] rx_cnt_q;

   always_ff @(posedge clk) begin
      if (reset)        rx_cnt_q <= '0;
      else if (capture) rx_cnt_q <= rx_cnt_q + 1'b1;
   end

   assign rx_count = rx_cnt_q;
`endif
endmodule
